// File: rtl/rv_result_serializer.sv
//------------------------------------------------------------------------------
// Module      : rv_result_serializer
// Description : Word FIFO feeding a shift-register transmitter that emits
//               result words LSB byte first on a valid/ready byte stream.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rv_result_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic [WORD_WIDTH-1:0] word_data,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic [BYTE_WIDTH-1:0] byte_data,
    output logic                  byte_first,
    output logic                  byte_last,
    output logic                  busy
);

    localparam int c_BEATS  = WORD_WIDTH / BYTE_WIDTH;
    localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL_CNT  = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [c_BEAT_W-1:0]   r_beat;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_shift;

    assign w_full     = (r_count == c_FULL_CNT);
    assign w_empty    = (r_count == '0);
    // Readiness depends only on fullness, so a pop cannot free a slot for the same edge.
    assign word_ready = ~w_full & ~rst;
    assign w_push     = word_valid & word_ready;
    assign byte_data  = r_shift[BYTE_WIDTH-1:0];
    assign busy       = ~w_empty | byte_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        byte_valid  = 1'b0;
        byte_first  = 1'b0;
        byte_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                byte_valid = 1'b1;
                byte_first = (r_beat == '0);
                byte_last  = (r_beat == c_LAST_BEAT);
                if (byte_ready) begin
                    if (r_beat != c_LAST_BEAT) begin
                        w_shift = 1'b1;
                    end else if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= word_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_beat  <= '0;
        end else if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_beat  <= '0;
        end else if (w_shift) begin
            r_shift <= r_shift >> BYTE_WIDTH;
            r_beat  <= r_beat + c_BEAT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv_result_serializer.sv
//------------------------------------------------------------------------------
// Module      : tb_rv_result_serializer
// Description : Scoreboard bench for rv_result_serializer (32-bit and 16-bit).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rv_result_serializer;

    localparam int WW    = 32;
    localparam int BW    = 8;
    localparam int DEPTH = 2;
    localparam int NB    = WW / BW;

    typedef struct packed {
        logic [BW-1:0] d;
        logic          f;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic [WW-1:0] word_data = '0;
    logic          byte_valid;
    logic          byte_ready = 1'b0;
    logic [BW-1:0] byte_data;
    logic          byte_first;
    logic          byte_last;
    logic          busy;

    logic          v16 = 1'b0;
    logic          rdy16_out;
    logic [15:0]   d16 = '0;
    logic          bv16;
    logic          br16 = 1'b1;
    logic [BW-1:0] bd16;
    logic          bf16;
    logic          bl16;
    logic          busy16;

    beat_t exp_q[$];
    beat_t mon_e;
    beat_t held;
    beat_t rec_e;
    int    n_cmp = 0;
    int    n_err = 0;
    int    acc_words = 0;
    int    started_words = 0;
    int    occ;
    logic  stall_prev = 1'b0;
    int    rdy_mode = 1;

    rv_result_serializer #(.WORD_WIDTH(WW), .BYTE_WIDTH(BW), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .byte_first(byte_first), .byte_last(byte_last), .busy(busy)
    );

    rv_result_serializer #(.WORD_WIDTH(16), .BYTE_WIDTH(BW), .FIFO_DEPTH(DEPTH)) u_dut16 (
        .clk(clk), .rst(rst),
        .word_valid(v16), .word_ready(rdy16_out), .word_data(d16),
        .byte_valid(bv16), .byte_ready(br16), .byte_data(bd16),
        .byte_first(bf16), .byte_last(bl16), .busy(busy16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected bytes for every accepted word, LSB byte first.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            exp_q.delete();
            acc_words = 0;
        end else if (word_valid && word_ready) begin
            for (int b = 0; b < NB; b++) begin
                rec_e.d = word_data[b*BW +: BW];
                rec_e.f = (b == 0);
                rec_e.l = (b == NB - 1);
                exp_q.push_back(rec_e);
            end
            acc_words++;
        end
    end

    // Words waiting in the FIFO = accepted words minus words whose first byte has appeared.
    always @(negedge clk) begin
        if (rst) begin
            started_words = 0;
            stall_prev    = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", {byte_valid, byte_data, byte_first, byte_last}, {1'b1, held});
            if (byte_valid && byte_first && !stall_prev)
                started_words++;
            occ = acc_words - started_words;
            check("word_ready", word_ready, (occ < DEPTH));
            check("busy", busy, ((occ != 0) || byte_valid));
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h with nothing expected (t=%0t)", byte_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat", {byte_data, byte_first, byte_last}, mon_e);
                end
            end
            stall_prev = byte_valid && !byte_ready;
            held       = {byte_data, byte_first, byte_last};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       byte_ready = 1'b0;
                1:       byte_ready = 1'b1;
                default: byte_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Call at posedge+1; returns at posedge+1 after the word is taken.
    task automatic push_word(input logic [WW-1:0] w);
        bit acc;
        acc = 1'b0;
        word_valid = 1'b1;
        word_data  = w;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = word_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: got no acceptance expected acceptance of %0h", w);
        end
        word_valid = 1'b0;
        word_data  = $urandom;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy) && i < 500) begin
            @(negedge clk);
            i++;
        end
        check({name, "_drain"}, (exp_q.size() == 0 && !busy), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  run;
        bit  seen;
        #1 rst = 1'b1;
        #1;
        check("rst_outputs", {byte_valid, byte_first, byte_last, busy, word_ready, byte_data}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", word_ready, 1);
        @(posedge clk);
        #1;

        push_word(32'hDEADBEEF);
        @(negedge clk);
        check("lat_idle", byte_valid, 0);
        @(negedge clk);
        check("lat_first", {byte_valid, byte_data, byte_first}, {1'b1, 8'hEF, 1'b1});
        @(posedge clk);
        #1;
        drain("single");

        push_word(32'h03020100);
        push_word(32'h07060504);
        run = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (byte_valid) run++;
            else if (run > 0) break;
        end
        check("b2b_run", run, 8);
        @(posedge clk);
        #1;
        drain("b2b");

        rdy_mode = 0;
        @(posedge clk);
        #1;
        push_word(32'h11223344);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold", {byte_valid, byte_data, byte_first}, {1'b1, 8'h44, 1'b1});
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        drain("bp");

        rdy_mode = 0;
        @(posedge clk);
        #1;
        push_word(32'hA1A1A1A1);
        push_word(32'hA2A2A2A2);
        push_word(32'hA3A3A3A3);
        @(negedge clk);
        check("full_ready", word_ready, 0);
        @(posedge clk);
        #1;
        word_valid = 1'b1;
        word_data  = 32'hA4A4A4A4;
        repeat (4) begin
            @(negedge clk);
            check("full_hold", word_ready, 0);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        push_word(32'hA4A4A4A4);
        drain("full");

        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            push_word($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 1;
        drain("rand");

        push_word(32'hAABBCCDD);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = byte_valid && byte_ready && (byte_data == 8'hDD);
        end
        check("rst_seen_dd", seen, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_async", {byte_valid, byte_first, byte_last, busy, word_ready, byte_data}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_quiet", {byte_valid, busy}, 0);
        end
        @(posedge clk);
        #1;
        push_word(32'h01020304);
        drain("after_rst");

        d16 = 16'hBEEF;
        v16 = 1'b1;
        @(negedge clk);
        check("w16_ready", rdy16_out, 1);
        @(posedge clk);
        #1;
        v16 = 1'b0;
        @(negedge clk);
        check("w16_idle", bv16, 0);
        @(negedge clk);
        check("w16_b0", {bv16, bd16, bf16, bl16}, {1'b1, 8'hEF, 1'b1, 1'b0});
        @(negedge clk);
        check("w16_b1", {bv16, bd16, bf16, bl16}, {1'b1, 8'hBE, 1'b0, 1'b1});
        @(negedge clk);
        check("w16_done", {bv16, busy16}, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv_result_serializer.md
Name: rv_result_serializer

Overview:
- Transmit-side companion to the core's 8-bit instruction input: takes 32-bit result words from the single-cycle datapath and streams them out over the 8-bit dedicated output pins.
- Small word FIFO on the input, then a shift-register transmitter emitting one byte per beat on a valid/ready byte stream, LSB byte first.
- Sits between the datapath result and uo_out in the TinyTapeout top.

Parameters:
- WORD_WIDTH, 32, result word width; integer multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, output beat width.
- FIFO_DEPTH, 2, word FIFO entries; power of two, >= 2.
- Derived (not overridable): BEATS = WORD_WIDTH/BYTE_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  FIFO can accept a word.
- word_data  input  WORD_WIDTH  result word from datapath.
- byte_valid  output  1  byte_data is valid.
- byte_ready  input  1  downstream accepts the byte.
- byte_data  output  BYTE_WIDTH  current beat.
- byte_first  output  1  current beat is byte 0 of a word.
- byte_last  output  1  current beat is byte BEATS-1 of a word.
- busy  output  1  FIFO non-empty or byte_valid high.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - FIFO pointers and count cleared.
  - Shift register, beat counter and byte_data cleared to 0.
  - byte_valid, byte_first, byte_last and busy are 0.
  - word_ready is forced 0 while rst is high and is 1 in the first cycle after deassert.
- Input handshake:
  - A word is pushed on a rising edge with word_valid && word_ready.
  - word_ready = !full. There is no pop-through: when full, a push is refused even if a pop occurs in the same cycle.
  - word_data is ignored when word_valid is low.
- FSM, two states:
  - IDLE: byte_valid=0. If the FIFO is non-empty, pop the head into the shift register, set beat=0, go to SEND.
  - SEND: byte_valid=1. byte_data = shift[BYTE_WIDTH-1:0]. byte_first = (beat==0). byte_last = (beat==BEATS-1).
- On a byte handshake (byte_valid && byte_ready):
  - beat < BEATS-1: shift right by BYTE_WIDTH, beat += 1.
  - beat == BEATS-1 and FIFO non-empty: pop the next word into the shift register, beat=0, stay in SEND. No bubble.
  - beat == BEATS-1 and FIFO empty: go to IDLE, byte_valid drops next cycle.
- Stall: while byte_valid && !byte_ready, byte_data, byte_first, byte_last and beat hold stable. A push to the FIFO may still occur.
- Latency: a word pushed at edge t is popped at edge t+1 if the transmitter is IDLE. byte_valid is high from edge t+1, so the first byte is seen in the cycle after t+1.
- Throughput: sustained 1 byte/cycle with byte_ready held high. One word is accepted every BEATS cycles at steady state.
- Simultaneous push and pop on a non-full FIFO: both occur; count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- Reset mid-word: the partial word and all queued words are discarded. No byte is emitted after reset until a new word is pushed.
- busy is combinational from count and byte_valid.

Test Plan:
- Single word: push 0xDEADBEEF at edge 1, byte_ready=1 → bytes EF, BE, AD, DE on consecutive cycles; byte_first on EF, byte_last on DE; byte_valid drops after DE; busy returns to 0.
- Back-to-back: push 0x03020100 then 0x07060504, byte_ready=1 → 8 consecutive beats 00..07 with no gap; byte_first on 00 and 04, byte_last on 03 and 07.
- Backpressure: push 0x11223344, hold byte_ready=0 for 5 cycles → byte_data=0x44 and byte_first=1 stay stable; release → 44, 33, 22, 11.
- Full FIFO: byte_ready=0, push three words while word_valid is held high → word_ready falls to 0 after the 3rd push (two queued plus one in the shifter); the 4th word is not accepted until the first word's last byte completes.
- Reset mid-word: push 0xAABBCCDD, pulse rst asynchronously (off clock edge) after byte 0xDD transfers → all outputs immediately 0; no further bytes emitted; after reset, push 0x01020304 → 04, 03, 02, 01.
- Width parameter: WORD_WIDTH=16, push 0xBEEF → EF (byte_first), BE (byte_last).
